// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns the PS/2 Set-2 byte stream into single-cycle
// make/break key events with extended flag, repeat filtering and prefix timeout.
module ps2_scancode_decoder #(
   parameter int TIMEOUT_CYCLES = 2_500_000,
   parameter int FILTER_REPEAT  = 1
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] ps2_data_i,
   input  logic       ps2_data_en_i,
   output logic [7:0] key_code_o,
   output logic       key_ext_o,
   output logic       key_break_o,
   output logic       key_en_o,
   output logic       err_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] code_q, code_d, last_code_q, last_code_d;
   logic ext_q, ext_d, brk_q, brk_d, ken_q, ken_d, err_q, err_d;
   logic last_vld_q, last_vld_d, last_ext_q, last_ext_d;
   logic is_e0, is_f0, drop, timeout, mk, bk, ev_ext, same_key, repeat_hit;
   always_comb begin
      is_e0   = ps2_data_i == 8'hE0;
      is_f0   = ps2_data_i == 8'hF0;
      drop    = ps2_data_i inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
      // Fires one cycle early so err_o lands exactly TIMEOUT_CYCLES after the prefix strobe.
      timeout = state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 2);
      state_d = state_q;
      err_d   = 1'b0;
      mk      = 1'b0;
      bk      = 1'b0;
      ev_ext  = 1'b0;
      if (ps2_data_en_i) begin
         case (state_q)
            IDLE: begin
               state_d = is_e0 ? GOT_E0 : is_f0 ? GOT_F0 : IDLE;
               mk      = !is_e0 && !is_f0 && !drop;
            end
            GOT_E0: begin
               state_d = is_f0 ? GOT_E0F0 : IDLE;
               err_d   = is_e0 || drop;
               mk      = !is_e0 && !is_f0 && !drop;
               ev_ext  = 1'b1;
            end
            default: begin
               state_d = IDLE;
               err_d   = is_e0 || is_f0 || drop;
               bk      = !(is_e0 || is_f0 || drop);
               ev_ext  = state_q == GOT_E0F0;
            end
         endcase
      end else if (timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
      cnt_d       = (ps2_data_en_i || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      same_key    = last_ext_q == ev_ext && last_code_q == ps2_data_i;
      repeat_hit  = FILTER_REPEAT != 0 && last_vld_q && same_key;
      ken_d       = bk || (mk && !repeat_hit);
      code_d      = ken_d ? ps2_data_i : code_q;
      ext_d       = ken_d ? ev_ext : ext_q;
      brk_d       = ken_d ? bk : brk_q;
      last_vld_d  = FILTER_REPEAT == 0 ? 1'b0 : (ken_d && mk) ? 1'b1 : (bk && same_key) ? 1'b0 : last_vld_q;
      last_code_d = (ken_d && mk) ? ps2_data_i : last_code_q;
      last_ext_d  = (ken_d && mk) ? ev_ext : last_ext_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         code_q      <= 8'h00;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         ken_q       <= 1'b0;
         err_q       <= 1'b0;
         last_vld_q  <= 1'b0;
         last_ext_q  <= 1'b0;
         last_code_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         ken_q       <= ken_d;
         err_q       <= err_d;
         last_vld_q  <= last_vld_d;
         last_ext_q  <= last_ext_d;
         last_code_q <= last_code_d;
      end
   end
   assign key_code_o  = code_q;
   assign key_ext_o   = ext_q;
   assign key_break_o = brk_q;
   assign key_en_o    = ken_q;
   assign err_o       = err_q;
endmodule
